slot_scheduler: RTL

- Round-robin scheduler for the 9-slot resource. It decides which slot owns the shared datapath and drives the 4-bit current-slot code consumed by the slot one-hot decoder.
- Each slot raises a level request. The scheduler grants one slot at a time, bounds ownership with a dwell timer, and inserts an idle gap between owners.
- While nothing is granted it drives the idle code 4'hF. The decoder maps any code of 9 or above to all-zero one-hot.

---
 rtl/slot_pkg.sv | 25 ++
 rtl/rr_pick.sv | 50 +++++
 rtl/slot_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/slot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slot_pkg
//  Description : Shared definitions for the 9-slot scheduler and its
//                picker. Provides the slot count, the idle slot code, the
//                slot index type and the scheduler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package slot_pkg;

    localparam int NUM_SLOTS = 9;

    // Any code of 9 or above decodes to an all-zero one-hot downstream.
    localparam logic [3:0] SLOT_IDLE_CODE = 4'hF;

    typedef logic [3:0] slot_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating-priority picker. Returns the first
//                set bit of the eligibility vector, searching upward from
//                the pointer and wrapping from the top slot back to slot 0.
//  Ports       : elig   - per-slot eligibility vector
//                ptr    - highest-priority slot index (0..NUM_SLOTS-1)
//                winner - index of the selected slot (0 when none)
//                any    - 1 when at least one slot is eligible
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import slot_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] elig,
    input  slot_idx_t            ptr,
    output slot_idx_t            winner,
    output logic                 any
);

    // Walk NUM_SLOTS candidates starting at ptr. The candidate index is
    // reduced modulo NUM_SLOTS by two conditional subtractions, which covers
    // every 4-bit pointer value even though only 0..NUM_SLOTS-1 is expected.
    function automatic slot_idx_t f_pick(input logic [NUM_SLOTS-1:0] v,
                                         input slot_idx_t p);
        slot_idx_t  w_sel;
        logic       w_found;
        logic [4:0] w_cand;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_cand = 5'(p) + 5'(k);
            if (w_cand >= 5'(NUM_SLOTS)) w_cand = w_cand - 5'(NUM_SLOTS);
            if (w_cand >= 5'(NUM_SLOTS)) w_cand = w_cand - 5'(NUM_SLOTS);
            if (!w_found && v[w_cand[3:0]]) begin
                w_sel   = w_cand[3:0];
                w_found = 1'b1;
            end
        end
        return w_sel;
    endfunction

    always_comb begin
        winner = f_pick(elig, ptr);
        any    = |elig;
    end

endmodule
`default_nettype wire

// File: rtl/slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : slot_scheduler
//  Description : Round-robin scheduler for the 9-slot shared datapath.
//                Grants one requesting slot at a time, bounds ownership
//                with a dwell timer and inserts an idle gap between owners.
//  Ports       : clk          - system clock, rising edge
//                reset        - synchronous active-high reset
//                enable       - allows new grants from IDLE
//                slot_mask    - per-slot eligibility
//                req          - per-slot level request
//                done         - owner release, honoured only in GRANT
//                current_slot - granted slot index, 4'hF when none
//                slot_valid   - current_slot holds a granted slot
//                grant_start  - pulse on the first cycle of a grant
//                timeout      - pulse when a grant ends by dwell expiry only
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_scheduler #(
    parameter int NUM_SLOTS  = 9,
    parameter int DWELL_MAX  = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_SLOTS-1:0] slot_mask,
    input  logic [NUM_SLOTS-1:0] req,
    input  logic                 done,
    output logic [3:0]           current_slot,
    output logic                 slot_valid,
    output logic                 grant_start,
    output logic                 timeout
);

    import slot_pkg::*;

    localparam logic [4:0] c_DWELL_LAST = 5'(DWELL_MAX - 1);
    localparam logic [2:0] c_GAP_LAST   = 3'(GAP_CYCLES - 1);
    localparam slot_idx_t  c_LAST_SLOT  = 4'(NUM_SLOTS - 1);

    state_t               r_state;
    slot_idx_t            r_slot;
    slot_idx_t            r_ptr;
    logic                 r_valid;
    logic                 r_start;
    logic                 r_timeout;
    logic [4:0]           r_dwell;
    logic [2:0]           r_gap;

    logic [NUM_SLOTS-1:0] w_elig;
    slot_idx_t            w_winner;
    logic                 w_any;
    logic                 w_owner_ok;
    logic                 w_expire;
    logic                 w_end;

    assign w_elig = req & slot_mask;

    rr_pick u_pick (
        .elig   (w_elig),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    // The owner stays eligible only while both its request and its mask bit
    // are high; a drop of either ends the grant.
    always_comb begin
        w_owner_ok = |(w_elig & ({{(NUM_SLOTS-1){1'b0}}, 1'b1} << r_slot));
        w_expire   = (r_dwell == c_DWELL_LAST);
        w_end      = done || !w_owner_ok || w_expire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_slot    <= SLOT_IDLE_CODE;
            r_ptr     <= '0;
            r_valid   <= 1'b0;
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            r_dwell   <= '0;
            r_gap     <= '0;
        end else begin
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable && w_any) begin
                        r_state <= GRANT;
                        r_slot  <= w_winner;
                        r_valid <= 1'b1;
                        r_start <= 1'b1;
                        r_dwell <= '0;
                        // Just-served slot becomes lowest priority next pick.
                        r_ptr   <= (w_winner == c_LAST_SLOT) ? '0 : w_winner + 4'd1;
                    end
                end
                GRANT: begin
                    if (w_end) begin
                        r_state   <= GAP;
                        r_slot    <= SLOT_IDLE_CODE;
                        r_valid   <= 1'b0;
                        r_gap     <= '0;
                        // Flag expiry only when nothing else ended the grant.
                        r_timeout <= w_expire && !done && w_owner_ok;
                    end else begin
                        r_dwell <= r_dwell + 5'd1;
                    end
                end
                GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign current_slot = r_slot;
    assign slot_valid   = r_valid;
    assign grant_start  = r_start;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire
